// File: rtl/sockit_spi_arb_if.sv
// Bundle of the two requester command streams, the shared SPI command and
// response streams, the two routed response streams and arbiter status.
interface sockit_spi_arb_if #(
  parameter int CDW = 32,
  parameter int RDW = 32
);
  logic           r_vld, r_lst, r_ren, r_rdy;
  logic [CDW-1:0] r_dat;
  logic           x_vld, x_lst, x_ren, x_rdy;
  logic [CDW-1:0] x_dat;
  logic           c_vld, c_rdy;
  logic [CDW-1:0] c_dat;
  logic           i_vld, i_rdy;
  logic [RDW-1:0] i_dat;
  logic           ri_vld, ri_rdy;
  logic [RDW-1:0] ri_dat;
  logic           xi_vld, xi_rdy;
  logic [RDW-1:0] xi_dat;
  logic [1:0]     arb_own;
  logic           arb_err;

  // arbiter side
  modport slave (
    input  r_vld, r_dat, r_lst, r_ren, output r_rdy,
    input  x_vld, x_dat, x_lst, x_ren, output x_rdy,
    output c_vld, c_dat, input c_rdy,
    input  i_vld, i_dat, output i_rdy,
    output ri_vld, ri_dat, input ri_rdy,
    output xi_vld, xi_dat, input xi_rdy,
    output arb_own, arb_err
  );

  // requester / serializer side
  modport master (
    output r_vld, r_dat, r_lst, r_ren, input r_rdy,
    output x_vld, x_dat, x_lst, x_ren, input x_rdy,
    input  c_vld, c_dat, output c_rdy,
    output i_vld, i_dat, input i_rdy,
    input  ri_vld, ri_dat, output ri_rdy,
    input  xi_vld, xi_dat, output xi_rdy,
    input  arb_own, arb_err
  );
endinterface

// File: rtl/sockit_spi_arb.sv
// Packet-level arbiter for the SPI command stream (XIP priority with a
// starvation limit for the register interface) plus in-order routing of
// response beats back to the requester that issued each read.
module sockit_spi_arb #(
  parameter int CDW  = 32,
  parameter int RDW  = 32,
  parameter int TGD  = 4,
  parameter int XLIM = 3
) (
  input logic             clk,
  input logic             rst,
  sockit_spi_arb_if.slave bus
);
  localparam int AW = $clog2(TGD);
  localparam int CW = (XLIM < 1) ? 1 : $clog2(XLIM + 1);

  typedef enum logic [1:0] {IDLE, RGN, XGN} state_t;
  typedef struct packed {
    logic           vld;
    logic           lst;
    logic           ren;
    logic [CDW-1:0] dat;
  } cmd_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  xcnt_q, xcnt_d;
  logic [1:0]     own_q, own_d;
  logic           err_q, err_d;
  logic [AW:0]    wp_q, wp_d, rp_q, rp_d;
  logic [TGD-1:0] tag_q, tag_d;

  cmd_t           r_cmd, x_cmd, o_cmd;
  logic           full, empty, head_x, stall, o_rdy, c_vld_w, push, pop, i_rdy_w;
  logic [RDW-1:0] rsp_dat;

  // Tag FIFO status: wrap bit distinguishes full from empty
  assign empty  = (wp_q == rp_q);
  assign full   = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign head_x = tag_q[rp_q[AW-1:0]];

  // Command mux: owner drives the stream, held back when its read has no tag slot
  always_comb begin
    r_cmd   = '{vld: bus.r_vld, lst: bus.r_lst, ren: bus.r_ren, dat: bus.r_dat};
    x_cmd   = '{vld: bus.x_vld, lst: bus.x_lst, ren: bus.x_ren, dat: bus.x_dat};
    o_cmd   = '0;
    if (state_q == RGN)      o_cmd = r_cmd;
    else if (state_q == XGN) o_cmd = x_cmd;
    stall   = o_cmd.ren && full;
    o_rdy   = bus.c_rdy && !stall && !rst;
    c_vld_w = o_cmd.vld && !stall && !rst;
    push    = c_vld_w && bus.c_rdy && o_cmd.ren;
    bus.c_vld = c_vld_w;
    bus.c_dat = o_cmd.dat;
    bus.r_rdy = (state_q == RGN) && o_rdy;
    bus.x_rdy = (state_q == XGN) && o_rdy;
  end

  // Response router: head tag selects the destination; empty FIFO sinks and flags
  always_comb begin
    rsp_dat    = bus.i_dat;
    i_rdy_w    = 1'b0;
    bus.ri_vld = 1'b0;
    bus.xi_vld = 1'b0;
    if (!rst) begin
      if (empty) begin
        i_rdy_w = 1'b1;
      end else if (head_x) begin
        bus.xi_vld = bus.i_vld;
        i_rdy_w    = bus.xi_rdy;
      end else begin
        bus.ri_vld = bus.i_vld;
        i_rdy_w    = bus.ri_rdy;
      end
    end
    pop        = bus.i_vld && i_rdy_w && !empty;
    err_d      = bus.i_vld && empty && !rst;
    bus.i_rdy  = i_rdy_w;
    bus.ri_dat = rsp_dat;
    bus.xi_dat = rsp_dat;
    bus.arb_own = own_q;
    bus.arb_err = err_q;
  end

  // Grant FSM, starvation counter and tag FIFO next state
  always_comb begin
    state_d = state_q;
    xcnt_d  = xcnt_q;
    case (state_q)
      IDLE: begin
        if (bus.x_vld && !(bus.r_vld && xcnt_q == CW'(XLIM))) begin
          state_d = XGN;
          if (!bus.r_vld)               xcnt_d = '0;
          else if (xcnt_q != CW'(XLIM)) xcnt_d = xcnt_q + 1'b1;
        end else if (bus.r_vld) begin
          state_d = RGN;
          xcnt_d  = '0;
        end
      end
      RGN, XGN: if (c_vld_w && bus.c_rdy && o_cmd.lst) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    own_d = {state_d == XGN, state_d == RGN};
    tag_d = tag_q;
    if (push) tag_d[wp_q[AW-1:0]] = (state_q == XGN);
    wp_d  = wp_q + (AW+1)'(push);
    rp_d  = rp_q + (AW+1)'(pop);
  end

  // State registers; reset aborts any packet and forgets outstanding tags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      xcnt_q  <= '0;
      own_q   <= '0;
      err_q   <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      xcnt_q  <= xcnt_d;
      own_q   <= own_d;
      err_q   <= err_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      tag_q   <= tag_d;
    end
  end
endmodule

// File: doc/sockit_spi_arb.md
Name: sockit_spi_arb

Overview:
Command-stream arbiter sharing one SPI command/response path between two requesters: the register interface (CPU-programmed cycles, requester R) and the XIP engine (requester X).
- Grants the command stream per packet, ending on the beat with lst=1.
- XIP has priority, with a starvation limit in favour of R.
- Routes each returned response beat to the requester that issued the matching read command, using an in-order owner-tag FIFO.
- Sits between the requesters and the SPI serializer's command/response streams.

Parameters:
CDW, 32, command data width
RDW, 32, response data width
TGD, 4, tag FIFO depth (outstanding read beats); power of 2, ≥2
XLIM, 3, max consecutive X grants while R is pending

Ports:
clk  in  1  clock
rst  in  1  reset
r_vld  in  1  R command beat valid
r_dat  in  CDW  R command data
r_lst  in  1  R last beat of packet
r_ren  in  1  R beat expects one response beat
r_rdy  out  1  R beat accepted
x_vld  in  1  X command beat valid
x_dat  in  CDW  X command data
x_lst  in  1  X last beat of packet
x_ren  in  1  X beat expects one response beat
x_rdy  out  1  X beat accepted
c_vld  out  1  command stream valid
c_dat  out  CDW  command stream data
c_rdy  in  1  command stream ready
i_vld  in  1  response beat valid
i_dat  in  RDW  response data
i_rdy  out  1  response accepted
ri_vld  out  1  response to R valid
ri_dat  out  RDW  response to R data
ri_rdy  in  1  R response ready
xi_vld  out  1  response to X valid
xi_dat  out  RDW  response to X data
xi_rdy  in  1  X response ready
arb_own  out  2  one-hot current owner {X,R}; 00 when idle
arb_err  out  1  one-cycle pulse: unexpected response dropped

Behaviour:
Clock and reset: one clock; reset is synchronous and active-high. Ports are named clk and rst.

Reset:
- FSM enters IDLE.
- Tag FIFO is emptied and xcnt is cleared to 0.
- c_vld, r_rdy, x_rdy, i_rdy, ri_vld, xi_vld, arb_err are 0; arb_own is 00.
- Reset mid-packet aborts the packet and forgets all outstanding tags.

FSM states: IDLE, RGN, XGN.
- IDLE → XGN if x_vld && !(r_vld && xcnt==XLIM).
- Otherwise IDLE → RGN if r_vld.
- Otherwise remain in IDLE.
- The decision registers at the clock edge. The first beat can transfer the cycle after the grant (1-cycle arbitration latency).
- RGN/XGN → IDLE on the cycle in which a beat with lst=1 transfers (vld&&rdy).
- There is always one IDLE cycle between packets.
- A requester dropping vld mid-packet stalls the stream; the grant is held and is never switched mid-packet.

Command path in a granted state (owner o):
- c_vld = o_vld and c_dat = o_dat.
- o_rdy = c_rdy && !(o_ren && tag_full).
- c_vld = 0 when o_ren && tag_full (no beat is presented without space for its tag).
- The non-owner rdy is 0. In IDLE, c_vld = 0 and both rdy are 0.

Starvation counter xcnt:
- On the IDLE→XGN transition, xcnt increments if r_vld=1, saturating at XLIM; otherwise it is cleared.
- On IDLE→RGN, xcnt is cleared.

Tag FIFO:
- Push owner id (0=R, 1=X) when a beat with ren=1 transfers.
- Pop when i_vld&&i_rdy and the FIFO is non-empty.
- Push is blocked when full, even if a pop occurs in the same cycle.
- There is no bypass: a response arriving while the FIFO is empty is unexpected, even if a push happens in the same cycle.
- Pointers are log2(TGD) bits plus a wrap bit; full/empty come from the wrap-bit compare.

Response routing, when the FIFO is non-empty:
- Head=R: ri_vld = i_vld, ri_dat = i_dat, i_rdy = ri_rdy.
- Head=X: xi_vld = i_vld, xi_dat = i_dat, i_rdy = xi_rdy.
- The other requester's vld is 0. Combinational pass-through, 0 latency.

Response routing, when the FIFO is empty:
- i_rdy = 1 and ri_vld = xi_vld = 0.
- i_vld=1 drops the beat and arb_err pulses high the next cycle.

Concurrency and outputs:
- Command and response paths run independently; responses for an earlier owner drain while a new owner sends.
- arb_own is registered from the FSM state.

Test Plan:
- R-only packet, 3 beats (ren=0,0,1; lst on 3rd), c_rdy=1 → grant 1 cycle after r_vld; beats on consecutive cycles; arb_own=01; IDLE after beat 3; one tag R pushed; i_dat=0xA5A5A5A5 appears on ri_dat, never on xi.
- R and X both continuously requesting 1-beat packets, XLIM=3 → grant order X,X,X,R,X,X,X,R; xcnt=0 after each R grant.
- X issues 5 ren=1 single-beat packets with no responses, TGD=4 → first 4 accepted; 5th held with x_rdy=0 and c_vld=0 until one response pops; then accepted the next cycle.
- Interleaved owners: R read then X read, responses 0x11 then 0x22 → 0x11 to ri, 0x22 to xi; xi_rdy=0 stalls i_rdy while head=X.
- i_vld=1 with FIFO empty → i_rdy=1, no ri/xi valid, arb_err=1 for exactly one cycle.
- rst asserted mid-packet with 2 tags outstanding → next cycle all outputs at reset values, FIFO empty; subsequent response flags arb_err.
